// File: rtl/fd_de_pipe.sv
// -----------------------------------------------------------------------------
// fd_de_pipe
//
// F/D and D/E pipeline registers with a stall responder. A stall request
// (putoff) freezes the fetch PC and the F/D register and loads a bubble (all
// zeros) into the D/E register. A small state machine tracks how long a stall
// lasts. When a stall runs longer than ERR_LIMIT consecutive cycles, it raises
// a sticky stall_err flag. stall_cnt counts every stalled cycle since reset and
// saturates instead of wrapping.
//
// Ports
//   clk        : sole clock, rising edge
//   reset      : asynchronous, active-low reset
//   putoff     : stall request from the hazard detector
//   npc        : next fetch PC chosen in F/D
//   F_instr    : instruction fetched at F_pc
//   D_rs_data  : forwarded rs operand of the D instruction
//   D_rt_data  : forwarded rt operand of the D instruction
//   D_ext      : extended immediate of the D instruction
//   D_bpj      : D instruction is a branch/jump
//   F_pc       : current fetch PC
//   D_instr    : F/D register instruction
//   D_pc       : F/D register PC
//   E_*        : D/E register contents
//   E_bpj      : D/E copy of D_bpj
//   E_bubble   : E stage holds an inserted bubble
//   stall_cnt  : saturating count of stalled cycles since reset
//   stall_err  : sticky flag for an over-long stall
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module fd_de_pipe #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter int unsigned ERR_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        putoff,
  input  logic [31:0] npc,
  input  logic [31:0] F_instr,
  input  logic [31:0] D_rs_data,
  input  logic [31:0] D_rt_data,
  input  logic [31:0] D_ext,
  input  logic        D_bpj,
  output logic [31:0] F_pc,
  output logic [31:0] D_instr,
  output logic [31:0] D_pc,
  output logic [31:0] E_instr,
  output logic [31:0] E_pc,
  output logic [31:0] E_rs_data,
  output logic [31:0] E_rt_data,
  output logic [31:0] E_ext,
  output logic        E_bpj,
  output logic        E_bubble,
  output logic [15:0] stall_cnt,
  output logic        stall_err
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_STALL = 2'd1;
  localparam logic [1:0] ST_ERR   = 2'd2;

  // The run counter is only 2 bits wide, so the limit is compared in that width.
  localparam logic [1:0] ERR_LIM  = 2'(ERR_LIMIT);

  logic [1:0] state_reg;
  logic [1:0] state_next;
  logic [1:0] run_reg;
  logic       enter_err;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN: begin
        if (putoff) state_next = ST_STALL;
      end
      ST_STALL: begin
        if (!putoff)                 state_next = ST_RUN;
        else if (run_reg == ERR_LIM) state_next = ST_ERR;
        else                         state_next = ST_STALL;
      end
      ST_ERR: begin
        if (!putoff) state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
  end

  assign enter_err = (state_reg == ST_STALL) && (state_next == ST_ERR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_RUN;
      run_reg   <= 2'd0;
      F_pc      <= PC_RESET;
      D_instr   <= 32'd0;
      D_pc      <= 32'd0;
      E_instr   <= 32'd0;
      E_pc      <= 32'd0;
      E_rs_data <= 32'd0;
      E_rt_data <= 32'd0;
      E_ext     <= 32'd0;
      E_bpj     <= 1'b0;
      E_bubble  <= 1'b0;
      stall_cnt <= 16'd0;
      stall_err <= 1'b0;
    end else begin
      state_reg <= state_next;
      // stall_err stays set after the first entry into ERR, whatever the state later.
      if (enter_err) stall_err <= 1'b1;

      if (putoff) begin
        // STALL and ERR both freeze F/D and send a nop down to E.
        if (run_reg != 2'd3)        run_reg   <= run_reg + 2'd1;
        if (stall_cnt != 16'hFFFF)  stall_cnt <= stall_cnt + 16'd1;
        E_instr   <= 32'd0;
        E_pc      <= 32'd0;
        E_rs_data <= 32'd0;
        E_rt_data <= 32'd0;
        E_ext     <= 32'd0;
        E_bpj     <= 1'b0;
        E_bubble  <= 1'b1;
      end else begin
        run_reg   <= 2'd0;
        F_pc      <= npc;
        D_instr   <= F_instr;
        D_pc      <= F_pc;
        E_instr   <= D_instr;
        E_pc      <= D_pc;
        E_rs_data <= D_rs_data;
        E_rt_data <= D_rt_data;
        E_ext     <= D_ext;
        E_bpj     <= D_bpj;
        E_bubble  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fd_de_pipe.sv
// -----------------------------------------------------------------------------
// tb_fd_de_pipe
//
// Self-checking bench for fd_de_pipe. Each scenario task drives the stimulus
// and does its own comparisons. A behavioural reference model tracks the
// expected outputs. It counts consecutive stall edges as a plain integer and
// raises the error flag once that count exceeds ERR_LIMIT.
// -----------------------------------------------------------------------------
module tb_fd_de_pipe;

  localparam logic [31:0] PC_RESET  = 32'h0000_3000;
  localparam int          ERR_LIMIT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        putoff = 1'b0;
  logic [31:0] npc = 32'd0;
  logic [31:0] F_instr = 32'd0;
  logic [31:0] D_rs_data = 32'd0;
  logic [31:0] D_rt_data = 32'd0;
  logic [31:0] D_ext = 32'd0;
  logic        D_bpj = 1'b0;
  logic [31:0] F_pc, D_instr, D_pc, E_instr, E_pc, E_rs_data, E_rt_data, E_ext;
  logic        E_bpj, E_bubble, stall_err;
  logic [15:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] m_fpc, m_dinstr, m_dpc, m_einstr, m_epc, m_ers, m_ert, m_eext;
  logic        m_ebpj, m_ebub, m_err;
  int          m_cnt, m_consec;

  fd_de_pipe #(.PC_RESET(PC_RESET), .ERR_LIMIT(ERR_LIMIT)) dut (
    .clk(clk), .reset(reset), .putoff(putoff), .npc(npc), .F_instr(F_instr),
    .D_rs_data(D_rs_data), .D_rt_data(D_rt_data), .D_ext(D_ext), .D_bpj(D_bpj),
    .F_pc(F_pc), .D_instr(D_instr), .D_pc(D_pc), .E_instr(E_instr), .E_pc(E_pc),
    .E_rs_data(E_rs_data), .E_rt_data(E_rt_data), .E_ext(E_ext), .E_bpj(E_bpj),
    .E_bubble(E_bubble), .stall_cnt(stall_cnt), .stall_err(stall_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_fpc = PC_RESET; m_dinstr = 0; m_dpc = 0; m_einstr = 0; m_epc = 0;
    m_ers = 0; m_ert = 0; m_eext = 0; m_ebpj = 0; m_ebub = 0; m_err = 0;
    m_cnt = 0; m_consec = 0;
  endtask

  // Apply the effect of one rising edge to the model, using the inputs as they are at that edge.
  task automatic model_step();
    if (!putoff) begin
      m_einstr = m_dinstr; m_epc = m_dpc;
      m_ers = D_rs_data; m_ert = D_rt_data; m_eext = D_ext; m_ebpj = D_bpj;
      m_ebub = 0;
      m_dinstr = F_instr; m_dpc = m_fpc; m_fpc = npc;
      m_consec = 0;
    end else begin
      m_einstr = 0; m_epc = 0; m_ers = 0; m_ert = 0; m_eext = 0; m_ebpj = 0;
      m_ebub = 1;
      m_consec++;
      if (m_cnt < 65535) m_cnt++;
      if (m_consec > ERR_LIMIT) m_err = 1;
    end
  endtask

  // Wait for one rising edge, update the model, then step #1 away from the edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Reset is asserted and released between clock edges.
  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    #3;
    model_reset();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk); #2;
    checks++; if (F_pc !== PC_RESET) begin failures++; $display("FAIL reset_fpc got=%h exp=%h", F_pc, PC_RESET); end
    checks++; if ({D_instr, D_pc, E_instr, E_pc} !== 128'd0) begin failures++; $display("FAIL reset_regs got=%h exp=0", {D_instr, D_pc, E_instr, E_pc}); end
    checks++; if ({E_rs_data, E_rt_data, E_ext} !== 96'd0) begin failures++; $display("FAIL reset_eops got=%h exp=0", {E_rs_data, E_rt_data, E_ext}); end
    checks++; if ({E_bpj, E_bubble, stall_err, stall_cnt} !== 19'd0) begin failures++; $display("FAIL reset_flags got=%h exp=0", {E_bpj, E_bubble, stall_err, stall_cnt}); end
    #3; model_reset(); reset = 1'b1;
  endtask

  task automatic test_free_run();
    putoff = 0; npc = m_fpc + 4; F_instr = 32'h8C01_0004;
    D_rs_data = 32'h1111; D_rt_data = 32'h2222; D_ext = 32'h4; D_bpj = 0;
    tick();
    checks++; if (F_pc !== 32'h3004) begin failures++; $display("FAIL free_fpc got=%h exp=00003004", F_pc); end
    npc = m_fpc + 4; F_instr = 32'h0000_0000;
    tick();
    checks++; if (E_instr !== 32'h8C01_0004) begin failures++; $display("FAIL free_einstr got=%h exp=8c010004", E_instr); end
    checks++; if (E_pc !== 32'h3000) begin failures++; $display("FAIL free_epc got=%h exp=00003000", E_pc); end
    checks++; if (E_bubble !== 1'b0) begin failures++; $display("FAIL free_bubble got=%b exp=0", E_bubble); end
    $display("free_run: F_pc=%h E_instr=%h E_pc=%h", F_pc, E_instr, E_pc);
  endtask

  task automatic test_single_stall();
    logic [31:0] pc_hold;
    apply_reset();
    putoff = 0; npc = m_fpc + 4; F_instr = 32'h1022_0003;
    tick();
    pc_hold = m_fpc;
    putoff = 1; npc = 32'hDEAD_BEE0; F_instr = 32'hFFFF_FFFF;
    tick();
    checks++; if (F_pc !== pc_hold) begin failures++; $display("FAIL stall1_fpc got=%h exp=%h", F_pc, pc_hold); end
    checks++; if (D_instr !== 32'h1022_0003) begin failures++; $display("FAIL stall1_dinstr got=%h exp=10220003", D_instr); end
    checks++; if (E_instr !== 32'd0 || E_bubble !== 1'b1) begin failures++; $display("FAIL stall1_e got=%h/%b exp=0/1", E_instr, E_bubble); end
    checks++; if (stall_cnt !== 16'd1) begin failures++; $display("FAIL stall1_cnt got=%0d exp=1", stall_cnt); end
    putoff = 0; npc = m_fpc + 4; F_instr = 32'h0;
    tick();
    checks++; if (E_instr !== 32'h1022_0003 || E_bubble !== 1'b0) begin failures++; $display("FAIL stall1_resume got=%h/%b exp=10220003/0", E_instr, E_bubble); end
    $display("single_stall: E_instr=%h stall_cnt=%0d", E_instr, stall_cnt);
  endtask

  task automatic test_long_stall();
    apply_reset();
    putoff = 0; npc = m_fpc + 4; F_instr = 32'hA5A5_0001;
    tick();
    putoff = 1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (stall_err !== (i == 4)) begin failures++; $display("FAIL long_err_edge%0d got=%b exp=%b", i, stall_err, (i == 4)); end
    end
    checks++; if (stall_cnt !== 16'd4) begin failures++; $display("FAIL long_cnt got=%0d exp=4", stall_cnt); end
    putoff = 0; npc = m_fpc + 4; F_instr = 32'h0;
    tick();
    checks++; if (F_pc !== 32'h3008 || E_bubble !== 1'b0) begin failures++; $display("FAIL long_advance got=%h/%b exp=00003008/0", F_pc, E_bubble); end
    checks++; if (stall_err !== 1'b1) begin failures++; $display("FAIL long_sticky got=%b exp=1", stall_err); end
    $display("long_stall: stall_cnt=%0d stall_err=%b", stall_cnt, stall_err);
  endtask

  task automatic test_random();
    int errs = 0;
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      putoff = ($urandom_range(0, 9) < 4);
      npc = $urandom; F_instr = $urandom; D_rs_data = $urandom;
      D_rt_data = $urandom; D_ext = $urandom; D_bpj = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (F_pc !== m_fpc || D_instr !== m_dinstr || D_pc !== m_dpc || E_instr !== m_einstr ||
          E_pc !== m_epc || E_rs_data !== m_ers || E_rt_data !== m_ert || E_ext !== m_eext ||
          E_bpj !== m_ebpj || E_bubble !== m_ebub || stall_cnt !== 16'(m_cnt) || stall_err !== m_err) begin
        failures++; errs++;
        if (errs < 10)
          $display("FAIL rand_cycle%0d got fpc=%h d=%h/%h e=%h/%h/%h/%h/%h bpj=%b bub=%b cnt=%0d err=%b exp fpc=%h d=%h/%h e=%h/%h/%h/%h/%h bpj=%b bub=%b cnt=%0d err=%b",
                   n, F_pc, D_instr, D_pc, E_instr, E_pc, E_rs_data, E_rt_data, E_ext, E_bpj, E_bubble, stall_cnt, stall_err,
                   m_fpc, m_dinstr, m_dpc, m_einstr, m_epc, m_ers, m_ert, m_eext, m_ebpj, m_ebub, m_cnt, m_err);
      end
    end
    $display("random: 400 cycles, stall_cnt=%0d stall_err=%b", stall_cnt, stall_err);
  endtask

  task automatic test_async_reset();
    apply_reset();
    putoff = 0; npc = m_fpc + 4; F_instr = 32'h1234_5678;
    tick();
    npc = m_fpc + 4;
    tick();
    putoff = 1;
    tick();
    tick();
    // Drop reset between edges while the stall is in progress.
    #2; reset = 1'b0;
    #1;
    checks++; if (F_pc !== 32'h3000) begin failures++; $display("FAIL async_fpc got=%h exp=00003000", F_pc); end
    checks++; if ({D_instr, D_pc, E_instr, E_pc, E_rs_data, E_rt_data, E_ext} !== 224'd0) begin failures++; $display("FAIL async_regs got=%h exp=0", {D_instr, D_pc, E_instr, E_pc}); end
    checks++; if ({E_bpj, E_bubble, stall_err, stall_cnt} !== 19'd0) begin failures++; $display("FAIL async_flags got=%h exp=0", {E_bpj, E_bubble, stall_err, stall_cnt}); end
    model_reset();
    reset = 1'b1;
    // The stall resumes from RUN, so stall_err should rise only after four more stall edges.
    putoff = 1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (stall_err !== m_err || stall_cnt !== 16'(m_cnt) || E_bubble !== 1'b1) begin
        failures++; $display("FAIL async_restall%0d got err=%b cnt=%0d bub=%b exp err=%b cnt=%0d bub=1", i, stall_err, stall_cnt, E_bubble, m_err, m_cnt);
      end
    end
    putoff = 0;
    $display("async_reset: F_pc=%h stall_cnt=%0d", F_pc, stall_cnt);
  endtask

  task automatic test_saturation();
    apply_reset();
    putoff = 1;
    for (int i = 0; i < 65535; i++) tick();
    checks++; if (stall_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_reach got=%h exp=ffff", stall_cnt); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (stall_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%h exp=ffff", stall_cnt); end
    checks++; if (stall_err !== 1'b1 || E_bubble !== 1'b1) begin failures++; $display("FAIL sat_flags got=%b/%b exp=1/1", stall_err, E_bubble); end
    putoff = 0;
    $display("saturation: stall_cnt=%h after %0d stall edges", stall_cnt, m_cnt >= 65535 ? 65540 : m_cnt);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_free_run();
    test_single_stall();
    test_long_stall();
    test_random();
    test_async_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
